// File: rtl/quad_port_pkg.sv
// rtl/quad_port_pkg.sv - shared types and the per-beat sum helper
//   sum_t   : 11-bit signed per-beat sum
//   entry_t : packed FIFO entry {e, f, g, h, sum}
//   state_t : FIFO controller state {ST_EMPTY, ST_PARTIAL, ST_FULL}
//   quad_sum: zext(e) + sext(f) + sext(g) + sext(h) in 11 bits
package quad_port_pkg;

  localparam int SUM_W = 11;

  typedef logic signed [SUM_W-1:0] sum_t;

  typedef struct packed {
    logic        [7:0] e;
    logic signed [7:0] f;
    logic signed [7:0] g;
    logic signed [7:0] h;
    sum_t              sum;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  // Range is -384..636, so 11 bits never overflow. The size casts extend
  // according to the operand's own signedness: e zero-extends, f/g/h sign-extend.
  function automatic sum_t quad_sum(input logic        [7:0] a,
                                    input logic signed [7:0] b,
                                    input logic signed [7:0] c,
                                    input logic signed [7:0] d);
    return sum_t'({3'b000, a}) + sum_t'(b) + sum_t'(c) + sum_t'(d);
  endfunction

endpackage

// File: rtl/quad_port_fifo.sv
// rtl/quad_port_fifo.sv - first-word-fall-through FIFO of entry_t
//   clk, rst          : clock, synchronous active-high reset
//   wr_valid/wr_ready : write handshake, wr_data is the entry to store
//   rd_valid/rd_ready : read handshake, rd_data is the head entry
module quad_port_fifo
  import quad_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_valid,
  output logic   wr_ready,
  input  entry_t wr_data,
  output logic   rd_valid,
  input  logic   rd_ready,
  output entry_t rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  state_t          state;
  state_t          state_nxt;
  logic            push;
  logic            pop;

  // Head comes straight from storage; there is no empty bypass, so a write
  // into an empty FIFO is visible only after the edge that stores it.
  assign rd_valid = (state != ST_EMPTY);
  assign rd_data  = mem[rd_ptr];
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign wr_ready = (state != ST_FULL) || (rd_valid && rd_ready);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable while rd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          state_nxt = (DEPTH == 1) ? ST_FULL : ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (push && !pop && (count == LAST_CNT)) begin
          state_nxt = ST_FULL;
        end else if (pop && !push && (count == ONE_CNT)) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop && !push) begin
          state_nxt = (DEPTH == 1) ? ST_EMPTY : ST_PARTIAL;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // count is kept alongside the state so the PARTIAL edges are decidable;
  // state and count always agree on empty/full.
  logic unused_full_cnt;
  assign unused_full_cnt = (count == FULL_CNT);

endmodule

// File: rtl/quad_port_collector.sv
// rtl/quad_port_collector.sv - per-beat sum, buffering FIFO, running total
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready, e..h   : producer beat (e unsigned, f/g/h signed)
//   out_valid/out_ready       : sink handshake on the FIFO head
//   out_e..out_h, out_sum     : head operands and its 11-bit signed sum
//   acc                       : wrapping signed total of accepted sums
//   beat_cnt                  : accepted beat count, wraps
//   ovf                       : sticky, push attempted while not ready
module quad_port_collector
  import quad_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic              [7:0] e,
  input  logic signed       [7:0] f,
  input  logic signed       [7:0] g,
  input  logic signed       [7:0] h,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic              [7:0] out_e,
  output logic signed       [7:0] out_f,
  output logic signed       [7:0] out_g,
  output logic signed       [7:0] out_h,
  output logic signed      [10:0] out_sum,
  output logic signed [ACC_W-1:0] acc,
  output logic             [15:0] beat_cnt,
  output logic                    ovf
);

  sum_t   beat_sum;
  entry_t wr_entry;
  entry_t head;
  logic   accept;

  assign beat_sum = quad_sum(e, f, g, h);
  assign accept   = in_valid && in_ready;

  always_comb begin
    wr_entry     = '0;
    wr_entry.e   = e;
    wr_entry.f   = f;
    wr_entry.g   = g;
    wr_entry.h   = h;
    wr_entry.sum = beat_sum;
  end

  quad_port_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (wr_entry),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (head)
  );

  assign out_e   = head.e;
  assign out_f   = head.f;
  assign out_g   = head.g;
  assign out_h   = head.h;
  assign out_sum = head.sum;

  // The size cast sign-extends the signed sum; the add wraps modulo 2^ACC_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (accept) begin
        acc      <= acc + ACC_W'(beat_sum);
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/quad_port_collector.md
# quad_port_collector

Downstream consumer for the four-output mixed-signedness port block (one unsigned 8-bit result plus three signed 8-bit results). Each accepted beat is reduced to one signed sum and buffered, together with the raw operands, in a small FIFO. A wrapping signed running total and a beat counter are also kept. The block decouples the producing stage from a slower sink through a valid/ready handshake on both sides.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; a power of two, 2..16.
- ACC_W, 16, width of the running-total accumulator; at least 11.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a beat.
- in_ready  output  1  the block can accept a beat.
- e  input  8  unsigned operand.
- f, g, h  input  8 each  signed operands (two's complement).
- out_valid  output  1  the FIFO head is valid.
- out_ready  input  1  the sink accepts the head.
- out_e  output  8  unsigned; the head's e.
- out_f, out_g, out_h  output  8 each  signed; the head's operands.
- out_sum  output  11  signed; the head's sum.
- acc  output  ACC_W  signed; running total of all accepted sums.
- beat_cnt  output  16  number of accepted beats; wraps.
- ovf  output  1  sticky flag: a push was attempted while full.

## Operation
Sum per beat:
- sum = zero-extend(e) + sign-extend(f) + sign-extend(g) + sign-extend(h), computed in 11-bit signed arithmetic.
- Range is -384..636, so the sum never overflows.

Accept and push:
- A beat is accepted when in_valid && in_ready.
- On accept, {e, f, g, h, sum} is written at the write pointer.
- acc += sign-extend(sum), wrapping modulo 2^ACC_W.
- beat_cnt += 1.

Pop:
- A pop occurs when out_valid && out_ready.
- The read pointer advances.

FIFO control:
- Occupancy count runs 0..DEPTH.
- in_ready = (count != DEPTH) || (out_valid && out_ready). Pass-through when full and popping in the same cycle is allowed.
- out_valid = (count != 0). Outputs come straight from the head entry register (first-word-fall-through).
- There is no bypass when empty: a beat written into an empty FIFO appears on out_* the next cycle.

Simultaneous push and pop:
- Count is unchanged.
- Both pointers advance.

ovf:
- Set when in_valid && !in_ready.
- Cleared only by rst.
- A producer that respects the handshake never sets it.

Controller state, derived from count:
- EMPTY: count == 0.
- PARTIAL: 0 < count < DEPTH.
- FULL: count == DEPTH.
- Transitions are by push/pop only.
- FULL with pop-only → PARTIAL, or EMPTY when DEPTH == 1.
- EMPTY with push-only → PARTIAL (FULL when DEPTH == 1; not a legal configuration).

Pointers are log2(DEPTH) bits wide and wrap naturally.

## Timing
Reset values (rst sampled high at an edge):
- count = 0, pointers = 0, acc = 0, beat_cnt = 0, ovf = 0.
- out_valid = 0; in_ready = 1 in the cycle after reset.
- out_* data is don't-care while out_valid = 0.

Latency:
- A push at edge N makes its entry visible on out_* after edge N when the FIFO was empty.
- acc and beat_cnt reflect the beat after edge N.

Handshake rules:
- in_ready depends combinationally on out_ready only through the full-and-popping term.
- There is no combinational path from in_valid to out_valid.
- The out_* data must hold stable while out_valid && !out_ready.

Reset mid-operation:
- Contents are discarded.
- The acc, beat_cnt and ovf values are cleared at that same edge.
- A beat presented in the reset cycle is not accepted.

## Structure
Shared package (quad_port_pkg):
- The 11-bit sum type.
- The packed entry struct {e, f, g, h, sum}.
- The state enum {EMPTY, PARTIAL, FULL}.
- The sum function.

Sub-module:
- One natural sub-module: quad_port_fifo, a parameterised storage plus pointer/count FWFT FIFO for the entry struct.
- The top level holds the sum, acc, beat_cnt and ovf logic.

## Test plan
1. Reset, then one beat e=8'd255, f=g=h=8'sd127, out_ready=1 → out_sum=636, acc=636, beat_cnt=1, out_valid high for exactly 1 cycle.
2. Beat e=0, f=g=h=-128 → out_sum=-384. A second beat e=200, f=-100, g=0, h=0 → sum=100 and acc=-284.
3. out_ready=0, push 4 beats → in_ready falls after the 4th. A 5th attempt with in_valid=1 sets ovf=1 and leaves count=4 and beat_cnt=4.
4. FIFO full, in_valid=1 and out_ready=1 in the same cycle → the beat is accepted, count stays 4, ordering is preserved, and ovf stays 0.
5. ACC_W=11, 4 beats of sum 636 → acc wraps to 2544 mod 2048 = 496; out_sum values are unaffected.
6. Assert rst with 3 entries queued and acc≠0 → the next cycle shows out_valid=0, acc=0, beat_cnt=0, ovf=0 and in_ready=1. The beat presented during rst is absent afterwards.
